// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: opcode map, ALU operation
// codes and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_SLTI = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  typedef enum logic {
    DEST_RD = 1'b0,
    DEST_RT = 1'b1
  } dest_sel_t;

  // Only the plain add/subtract arithmetic opcodes refresh the sticky carry.
  function automatic logic updates_carry(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction, ALU and write-back/branch signals seen by the
// issue controller; master is the controller, slave is its environment.
interface alu_issue_ctrl_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [WIDTH-1:0] in_rs_data;
  logic [WIDTH-1:0] in_rt_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [3:0]       alu_shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [1:0]       wb_addr;
  logic             wb_we;
  logic             br_taken;
  logic [WIDTH-1:0] br_offset;
  logic             illegal;
  logic             carry_flag;

  modport master (
    input  in_valid, in_instr, in_rs_data, in_rt_data,
    output in_ready,
    output alu_a, alu_b, alu_op, alu_shamt,
    input  alu_result, alu_zero, alu_carry,
    output wb_valid, wb_data, wb_addr, wb_we, br_taken, br_offset, illegal, carry_flag,
    input  wb_ready
  );

  modport slave (
    output in_valid, in_instr, in_rs_data, in_rt_data,
    input  in_ready,
    input  alu_a, alu_b, alu_op, alu_shamt,
    output alu_result, alu_zero, alu_carry,
    input  wb_valid, wb_data, wb_addr, wb_we, br_taken, br_offset, illegal, carry_flag,
    output wb_ready
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational opcode decoder: ALU operation, B-operand source, destination
// field and write-back/branch qualifiers.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] alu_op,
  output logic       b_sel_imm,
  output dest_sel_t  dest_sel,
  output logic       wb_we,
  output logic       is_branch,
  output logic       branch_ne,
  output logic       illegal
);

  always_comb begin
    alu_op    = ALU_ADD;
    b_sel_imm = 1'b0;
    dest_sel  = DEST_RD;
    wb_we     = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_op = ALU_ADD; wb_we = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; wb_we = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; wb_we = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  wb_we = 1'b1; end
      OP_SLT:  begin alu_op = ALU_SLT; wb_we = 1'b1; end
      OP_SLL:  begin alu_op = ALU_SLL; wb_we = 1'b1; end
      OP_SRA:  begin alu_op = ALU_SRA; wb_we = 1'b1; end
      OP_ADDI: begin
        alu_op    = ALU_ADD;
        b_sel_imm = 1'b1;
        dest_sel  = DEST_RT;
        wb_we     = 1'b1;
      end
      OP_SLTI: begin
        alu_op    = ALU_SLT;
        b_sel_imm = 1'b1;
        dest_sel  = DEST_RT;
        wb_we     = 1'b1;
      end
      OP_BEQ:  begin alu_op = ALU_SUB; is_branch = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; is_branch = 1'b1; branch_ne = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 16-bit ALU: accepts an instruction, drives the ALU
// for one cycle, then holds the write-back/branch packet until consumed.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input logic        clk,
  input logic        reset,
  alu_issue_ctrl_if.master bus
);

  state_t state, state_next;

  logic [15:0]      instr_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;

  logic [WIDTH-1:0] wb_data_q;
  logic [1:0]       wb_addr_q;
  logic             wb_we_q;
  logic             br_taken_q;
  logic [WIDTH-1:0] br_offset_q;
  logic             illegal_q;
  logic             carry_flag_q;

  logic [3:0]       dec_alu_op;
  logic             dec_b_sel_imm;
  dest_sel_t        dec_dest_sel;
  logic             dec_wb_we;
  logic             dec_is_branch;
  logic             dec_branch_ne;
  logic             dec_illegal;

  logic [WIDTH-1:0] imm_ext;
  logic             accept;
  logic             unused_rs_field;

  alu_issue_decode u_decode (
    .opcode    (instr_q[15:12]),
    .alu_op    (dec_alu_op),
    .b_sel_imm (dec_b_sel_imm),
    .dest_sel  (dec_dest_sel),
    .wb_we     (dec_wb_we),
    .is_branch (dec_is_branch),
    .branch_ne (dec_branch_ne),
    .illegal   (dec_illegal)
  );

  // Register operands come in as data, so the rs field itself is never needed.
  assign unused_rs_field = ^instr_q[11:10];

  assign imm_ext = {{(WIDTH-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
  assign accept  = (state == S_IDLE) && bus.in_valid;

  assign bus.alu_a     = dec_illegal ? '0 : rs_q;
  assign bus.alu_b     = dec_illegal ? '0 : (dec_b_sel_imm ? imm_ext : rt_q);
  assign bus.alu_op    = dec_alu_op;
  assign bus.alu_shamt = ((dec_alu_op == ALU_SLL) || (dec_alu_op == ALU_SRA)) ?
                         instr_q[3:0] : 4'd0;

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.wb_valid   = (state == S_WB);
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.br_taken   = br_taken_q;
  assign bus.br_offset  = br_offset_q;
  assign bus.illegal    = illegal_q;
  assign bus.carry_flag = carry_flag_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    if (bus.wb_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The packet registers load only at the end of EXEC, so they stay frozen
  // throughout WB regardless of how long the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      wb_data_q    <= '0;
      wb_addr_q    <= '0;
      wb_we_q      <= 1'b0;
      br_taken_q   <= 1'b0;
      br_offset_q  <= '0;
      illegal_q    <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= bus.in_instr;
        rs_q    <= bus.in_rs_data;
        rt_q    <= bus.in_rt_data;
      end
      if (state == S_EXEC) begin
        wb_data_q   <= bus.alu_result;
        wb_addr_q   <= (dec_dest_sel == DEST_RT) ? instr_q[9:8] : instr_q[7:6];
        wb_we_q     <= dec_wb_we;
        br_taken_q  <= dec_is_branch & (dec_branch_ne ^ bus.alu_zero);
        br_offset_q <= imm_ext;
        illegal_q   <= dec_illegal;
        if (updates_carry(instr_q[15:12])) carry_flag_q <= bus.alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU plus an
// instruction-level reference model driven by directed and random stimulus.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(16)) bus ();

  alu_issue_ctrl #(.WIDTH(16), .IMM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_carry = 1'b0;

  typedef struct packed {
    logic [15:0] a, b;
    logic [3:0]  op, sh;
    logic        chk_b;
    logic [15:0] data;
    logic [1:0]  addr;
    logic        we, taken;
    logic [15:0] off;
    logic        ill, carry;
  } exp_t;

  typedef struct packed {
    logic [15:0] a, b;
    logic [3:0]  op, sh;
    logic        exec_ready, wbv;
    logic [15:0] data;
    logic [1:0]  addr;
    logic        we, taken;
    logic [15:0] off;
    logic        ill, carry, stable, idle_after, timeout;
  } obs_t;

  // Behavioural ALU the controller drives.
  logic [16:0] alu_ext;
  always_comb begin
    alu_ext = 17'd0;
    case (bus.alu_op)
      ALU_ADD: alu_ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      ALU_SUB: alu_ext = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
      ALU_AND: alu_ext = {1'b0, bus.alu_a & bus.alu_b};
      ALU_OR:  alu_ext = {1'b0, bus.alu_a | bus.alu_b};
      ALU_SLT: alu_ext = {16'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      ALU_SLL: alu_ext = {1'b0, bus.alu_a << bus.alu_shamt};
      ALU_SRA: alu_ext = {1'b0, $signed(bus.alu_a) >>> bus.alu_shamt};
      default: alu_ext = 17'd0;
    endcase
  end
  assign bus.alu_result = alu_ext[15:0];
  assign bus.alu_zero   = (alu_ext[15:0] == 16'd0);
  assign bus.alu_carry  = ((bus.alu_op == ALU_ADD) || (bus.alu_op == ALU_SUB)) ? alu_ext[16] : 1'b0;

  // Instruction-level reference: what one instruction must produce.
  function automatic exp_t model(input logic [15:0] instr, rs, rt, input logic carry_in);
    exp_t e;
    logic [15:0] imm;
    logic [3:0]  sh;
    imm = 16'($signed(instr[7:0]));
    sh  = instr[3:0];
    e = '0;
    e.a = rs; e.b = rt; e.chk_b = 1'b1; e.op = ALU_ADD; e.off = imm;
    e.carry = carry_in; e.addr = instr[7:6]; e.we = 1'b1;
    case (instr[15:12])
      4'd0: begin e.data = rs + rt; e.carry = (int'(rs) + int'(rt)) > 65535; end
      4'd1: begin e.op = ALU_SUB; e.data = rs - rt; e.carry = (rs >= rt); end
      4'd2: begin e.op = ALU_AND; e.data = rs & rt; end
      4'd3: begin e.op = ALU_OR;  e.data = rs | rt; end
      4'd4: begin e.op = ALU_SLT; e.data = ($signed(rs) < $signed(rt)) ? 16'd1 : 16'd0; end
      4'd5: begin e.op = ALU_SLL; e.sh = sh; e.chk_b = 1'b0; e.data = rs << sh; end
      4'd6: begin e.op = ALU_SRA; e.sh = sh; e.chk_b = 1'b0; e.data = 16'($signed(rs) >>> sh); end
      4'd7: begin
        e.b = imm; e.addr = instr[9:8]; e.data = rs + imm;
        e.carry = (int'(rs) + int'(imm)) > 65535;
      end
      4'd8: begin
        e.op = ALU_SLT; e.b = imm; e.addr = instr[9:8];
        e.data = ($signed(rs) < $signed(imm)) ? 16'd1 : 16'd0;
      end
      4'd9:  begin e.op = ALU_SUB; e.we = 1'b0; e.taken = (rs == rt); e.data = rs - rt; end
      4'd10: begin e.op = ALU_SUB; e.we = 1'b0; e.taken = (rs != rt); e.data = rs - rt; end
      default: begin e.ill = 1'b1; e.we = 1'b0; e.a = 16'd0; e.b = 16'd0; e.data = 16'd0; end
    endcase
    return e;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Runs one instruction end to end, recording what the DUT showed in EXEC and WB.
  task automatic issue(input logic [15:0] instr, rs, rt, input int hold, output obs_t o);
    int cyc;
    logic [36:0] first_pkt;
    o = '0;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    o.timeout = (cyc >= 20);
    bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_rs_data = rs; bus.in_rt_data = rt;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_instr = 16'($urandom);
    bus.in_rs_data = 16'($urandom); bus.in_rt_data = 16'($urandom);
    o.a = bus.alu_a; o.b = bus.alu_b; o.op = bus.alu_op; o.sh = bus.alu_shamt;
    o.exec_ready = bus.in_ready;
    @(negedge clk);
    o.wbv = bus.wb_valid; o.data = bus.wb_data; o.addr = bus.wb_addr; o.we = bus.wb_we;
    o.taken = bus.br_taken; o.off = bus.br_offset; o.ill = bus.illegal; o.carry = bus.carry_flag;
    first_pkt = {bus.wb_data, bus.wb_addr, bus.wb_we, bus.br_taken, bus.br_offset, bus.illegal};
    repeat (hold) @(negedge clk);
    o.stable = (first_pkt === {bus.wb_data, bus.wb_addr, bus.wb_we, bus.br_taken,
                               bus.br_offset, bus.illegal}) && (bus.wb_valid === 1'b1);
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    o.idle_after = bus.in_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 16'h0180; bus.in_rs_data = 16'h0005; bus.in_rt_data = 16'h0003;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_handshake: got ready=%b valid=%b expected 1/0", bus.in_ready, bus.wb_valid);
    end
    n_tests++;
    if ({bus.wb_data, bus.wb_addr, bus.wb_we, bus.br_taken, bus.br_offset, bus.illegal, bus.carry_flag} !== 37'd0) begin
      n_fail++; $display("[TB] FAIL reset_packet: got data=%h addr=%h we=%b tk=%b off=%h ill=%b c=%b expected all 0",
                         bus.wb_data, bus.wb_addr, bus.wb_we, bus.br_taken, bus.br_offset, bus.illegal, bus.carry_flag);
    end
    n_tests++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt} !== {16'd0, 16'd0, ALU_ADD, 4'd0}) begin
      n_fail++; $display("[TB] FAIL reset_alu: got a=%h b=%h op=%h sh=%h expected 0/0/%h/0",
                         bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt, ALU_ADD);
    end
    reset = 1'b0; bus.in_valid = 1'b0; exp_carry = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.wb_valid !== 1'b0 || bus.alu_a !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_wins_accept: got valid=%b alu_a=%h expected 0/0000", bus.wb_valid, bus.alu_a);
    end
  endtask

  logic [15:0] d_instr [5] = '{16'h0180, 16'h1040, 16'h91F0, 16'h60C2, 16'h8301};
  logic [15:0] d_rs    [5] = '{16'h7FFF, 16'h0000, 16'h1234, 16'h8004, 16'hFFFF};
  logic [15:0] d_rt    [5] = '{16'h0001, 16'h0001, 16'h1234, 16'h0000, 16'h0000};
  logic [15:0] d_data  [5] = '{16'h8000, 16'hFFFF, 16'h0000, 16'hE001, 16'h0001};
  logic [3:0]  d_op    [5] = '{4'b0010, 4'b1010, 4'b1010, 4'b0101, 4'b1011};
  logic [3:0]  d_sh    [5] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd0};

  task automatic test_directed();
    obs_t o;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e = model(d_instr[i], d_rs[i], d_rt[i], exp_carry);
      issue(d_instr[i], d_rs[i], d_rt[i], 0, o);
      n_tests++;
      if (o.op !== d_op[i] || o.sh !== d_sh[i]) begin
        n_fail++; $display("[TB] FAIL dir%0d_alu_op: got op=%h sh=%h expected %h/%h", i, o.op, o.sh, d_op[i], d_sh[i]);
      end
      n_tests++;
      if (o.data !== d_data[i] || o.wbv !== 1'b1) begin
        n_fail++; $display("[TB] FAIL dir%0d_wb_data: got %h valid=%b expected %h valid=1", i, o.data, o.wbv, d_data[i]);
      end
      n_tests++;
      if ({o.we, o.we ? o.addr : 2'b00, o.taken, o.off, o.ill, o.carry} !==
          {e.we, e.we ? e.addr : 2'b00, e.taken, e.off, e.ill, e.carry}) begin
        n_fail++; $display("[TB] FAIL dir%0d_packet: got we=%b addr=%h tk=%b off=%h ill=%b c=%b expected %b/%h/%b/%h/%b/%b",
                           i, o.we, o.addr, o.taken, o.off, o.ill, o.carry, e.we, e.addr, e.taken, e.off, e.ill, e.carry);
      end
      exp_carry = e.carry;
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    issue(16'hC123, 16'h5555, 16'hAAAA, 1, o);
    n_tests++;
    if ({o.ill, o.we, o.taken, o.wbv} !== 4'b1001) begin
      n_fail++; $display("[TB] FAIL illegal_flags: got ill=%b we=%b tk=%b valid=%b expected 1/0/0/1", o.ill, o.we, o.taken, o.wbv);
    end
    n_tests++;
    if ({o.a, o.b, o.op, o.sh} !== {16'd0, 16'd0, ALU_ADD, 4'd0} || o.carry !== exp_carry) begin
      n_fail++; $display("[TB] FAIL illegal_alu: got a=%h b=%h op=%h sh=%h c=%b expected 0/0/%h/0 c=%b",
                         o.a, o.b, o.op, o.sh, o.carry, ALU_ADD, exp_carry);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    logic [15:0] i1, i2;
    i1 = 16'h0240; i2 = 16'h3080;
    e1 = model(i1, 16'h1111, 16'h2222, exp_carry);
    e2 = model(i2, 16'h0F0F, 16'hF000, e1.carry);
    bus.in_valid = 1'b1; bus.in_instr = i1; bus.in_rs_data = 16'h1111; bus.in_rt_data = 16'h2222;
    @(negedge clk);
    bus.in_instr = i2; bus.in_rs_data = 16'h0F0F; bus.in_rt_data = 16'hF000;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.alu_a !== 16'h1111) begin
      n_fail++; $display("[TB] FAIL bp_exec: got ready=%b alu_a=%h expected 0/1111", bus.in_ready, bus.alu_a);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_data !== e1.data || bus.wb_addr !== e1.addr) begin
        n_fail++; $display("[TB] FAIL bp_hold%0d: got ready=%b valid=%b data=%h addr=%h expected 0/1/%h/%h",
                           c, bus.in_ready, bus.wb_valid, bus.wb_data, bus.wb_addr, e1.data, e1.addr);
      end
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_release: got ready=%b valid=%b expected 1/0", bus.in_ready, bus.wb_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.alu_a !== 16'h0F0F || bus.alu_op !== ALU_OR) begin
      n_fail++; $display("[TB] FAIL bp_next_accept: got alu_a=%h op=%h expected 0f0f/%h", bus.alu_a, bus.alu_op, ALU_OR);
    end
    @(negedge clk);
    n_tests++;
    if (bus.wb_data !== e2.data || bus.wb_addr !== e2.addr || bus.carry_flag !== e2.carry) begin
      n_fail++; $display("[TB] FAIL bp_next_packet: got data=%h addr=%h c=%b expected %h/%h/%b",
                         bus.wb_data, bus.wb_addr, bus.carry_flag, e2.data, e2.addr, e2.carry);
    end
    exp_carry = e2.carry;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    obs_t o;
    int seen;
    for (int phase = 0; phase < 2; phase++) begin
      issue(16'h0180, 16'hFFFF, 16'h0001, 0, o);
      n_tests++;
      if (o.carry !== 1'b1) begin
        n_fail++; $display("[TB] FAIL midrst%0d_carry_set: got %b expected 1", phase, o.carry);
      end
      bus.in_valid = 1'b1; bus.in_instr = 16'h1040; bus.in_rs_data = 16'h0005; bus.in_rt_data = 16'h0003;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (phase == 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_tests++;
      if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.carry_flag !== 1'b0 || bus.wb_data !== 16'd0) begin
        n_fail++; $display("[TB] FAIL midrst%0d_state: got valid=%b ready=%b c=%b data=%h expected 0/1/0/0000",
                           phase, bus.wb_valid, bus.in_ready, bus.carry_flag, bus.wb_data);
      end
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus.wb_valid === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
        n_fail++; $display("[TB] FAIL midrst%0d_no_packet: got %0d valid cycles expected 0", phase, seen);
      end
      exp_carry = 1'b0;
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [15:0] instr, rs, rt;
    for (int n = 0; n < 40; n++) begin
      instr = {4'($urandom_range(0, 15)), 12'($urandom)};
      rs = pick_operand();
      rt = ($urandom_range(0, 3) == 0) ? rs : pick_operand();
      e = model(instr, rs, rt, exp_carry);
      issue(instr, rs, rt, $urandom_range(0, 2), o);
      n_tests++;
      if (o.timeout || o.exec_ready !== 1'b0 || o.wbv !== 1'b1 || o.stable !== 1'b1 || o.idle_after !== 1'b1) begin
        n_fail++; $display("[TB] FAIL rnd%0d_handshake: got to=%b exec_ready=%b valid=%b stable=%b idle=%b expected 0/0/1/1/1",
                           n, o.timeout, o.exec_ready, o.wbv, o.stable, o.idle_after);
      end
      n_tests++;
      if ({o.a, e.chk_b ? o.b : 16'd0, o.op, o.sh} !== {e.a, e.chk_b ? e.b : 16'd0, e.op, e.sh}) begin
        n_fail++; $display("[TB] FAIL rnd%0d_alu_in instr=%h: got a=%h b=%h op=%h sh=%h expected %h/%h/%h/%h",
                           n, instr, o.a, o.b, o.op, o.sh, e.a, e.b, e.op, e.sh);
      end
      n_tests++;
      if ({o.data, o.we ? o.addr : 2'b00, o.we, o.taken, o.off, o.ill, o.carry} !==
          {e.data, e.we ? e.addr : 2'b00, e.we, e.taken, e.off, e.ill, e.carry}) begin
        n_fail++; $display("[TB] FAIL rnd%0d_packet instr=%h rs=%h rt=%h: got d=%h a=%h we=%b tk=%b off=%h ill=%b c=%b expected %h/%h/%b/%b/%h/%b/%b",
                           n, instr, rs, rt, o.data, o.addr, o.we, o.taken, o.off, o.ill, o.carry,
                           e.data, e.addr, e.we, e.taken, e.off, e.ill, e.carry);
      end
      exp_carry = e.carry;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.wb_ready = 1'b0;
    bus.in_instr = 16'd0; bus.in_rs_data = 16'd0; bus.in_rt_data = 16'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Driving end of the 16-bit ALU interface: the issue/control sequencer that feeds the ALU and collects its outputs.
- Accepts one instruction per valid/ready handshake, together with its two register operands.
- Decodes the opcode into ALU operation code, shift amount and operands, then registers the ALU's Result/Zero/CarryOut.
- Presents a write-back/branch packet to the pipeline under a second valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width; must match the ALU (only 16 is supported).
- IMM_W, 8, I-type immediate width; sign-extended to WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction available
- in_ready  out  1  block can accept an instruction
- in_instr  in  16  {opcode[15:12], rs[11:10], rt[9:8], rd[7:6], shamt[3:0]}; imm = in_instr[7:0]
- in_rs_data  in  WIDTH  rs operand
- in_rt_data  in  WIDTH  rt operand
- alu_a  out  WIDTH  ALU A input
- alu_b  out  WIDTH  ALU B input
- alu_op  out  4  ALU operation code
- alu_shamt  out  4  ALU shift amount
- alu_result  in  WIDTH  ALU Result
- alu_zero  in  1  ALU Zero
- alu_carry  in  1  ALU CarryOut
- wb_valid  out  1  packet valid
- wb_ready  in  1  consumer accepts the packet
- wb_data  out  WIDTH  captured result
- wb_addr  out  2  destination register
- wb_we  out  1  register write enable
- br_taken  out  1  branch taken
- br_offset  out  WIDTH  sign-extended imm
- illegal  out  1  undefined opcode
- carry_flag  out  1  sticky carry status

Behaviour:
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid, latch instr and operands, decode, go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_op/alu_shamt come from the latched decode; the ALU is combinational.
  - At the end of the cycle, capture alu_result/zero/carry into the wb registers; go to WB.
- WB:
  - wb_valid=1; all wb_* and br_* are stable until wb_ready.
  - On wb_ready, go to IDLE.
- Latency: accept at edge T; ALU inputs valid in cycle T+1; wb_valid high from T+2. Maximum throughput is 1 instruction per 3 cycles.
- in_ready is 0 in EXEC and WB. in_valid is ignored outside IDLE.
- Opcode map (opcode: ALU op, B operand, write-back/branch):
  - 0 ADD: ALU_ADD, B=rt, wb rd
  - 1 SUB: ALU_SUB, B=rt, wb rd
  - 2 AND: ALU_AND, B=rt, wb rd
  - 3 OR: ALU_OR, B=rt, wb rd
  - 4 SLT: ALU_SLT, B=rt, wb rd
  - 5 SLL: ALU_SLL, A=rs, wb rd, shamt=instr[3:0]
  - 6 SRA: ALU_SRA, A=rs, wb rd, shamt=instr[3:0]
  - 7 ADDI: ALU_ADD, B=sext(imm), wb rt
  - 8 SLTI: ALU_SLT, B=sext(imm), wb rt
  - 9 BEQ: ALU_SUB, B=rt, wb_we=0, br_taken=zero
  - 10 BNE: ALU_SUB, B=rt, wb_we=0, br_taken=~zero
  - 11-15: illegal=1, wb_we=0, br_taken=0, alu_op=ALU_ADD, A=B=0
- alu_shamt is 0 for all non-shift opcodes.
- br_offset = sext(imm) for every opcode; it is meaningful only when br_taken=1.
- carry_flag:
  - Updated at the EXEC capture only for ADD, SUB, ADDI; holds otherwise.
  - Not cleared by branches.
- Arithmetic is modulo 2^WIDTH; the block has no overflow output.
- Reset (any state, including mid-EXEC/WB):
  - Next state IDLE.
  - in_ready=1 after the first clk edge with reset high.
  - wb_valid=0, wb_data=0, wb_addr=0, wb_we=0, br_taken=0, br_offset=0, illegal=0, carry_flag=0.
  - alu_a=alu_b=0, alu_op=ALU_ADD, alu_shamt=0.
  - Any in-flight instruction is discarded.
- Simultaneous in_valid and reset: reset wins; nothing is accepted.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants OP_ADD..OP_BNE.
  - ALU op codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b1010, ALU_SLT=4'b1011, ALU_SLL=4'b0100, ALU_SRA=4'b0101.
  - FSM state encodings.
- Sub-module alu_issue_decode (combinational) maps opcode to {alu_op, b_sel_imm, dest_sel, wb_we, is_branch, branch_ne, illegal}.
- The top level holds the FSM, latches and capture registers.

Test Plan:
- ADD: rs=0x7FFF, rt=0x0001, rd=2 -> alu_op=0010; 2 cycles after accept: wb_data=0x8000, wb_addr=2, wb_we=1, carry_flag=0.
- SUB: rs=0x0000, rt=0x0001, then BEQ with rs=rt=0x1234, imm=0xF0:
  - SUB -> wb_data=0xFFFF; carry_flag per ALU CarryOut.
  - BEQ -> br_taken=1, br_offset=0xFFF0, wb_we=0, carry_flag unchanged.
- SRA: rs=0x8004, shamt=2 -> alu_op=0101, alu_shamt=2, wb_data=0xE001. SLTI: rs=0xFFFF (-1), imm=0x01 -> wb_data=0x0001, wb_addr=rt.
- Back-pressure: hold wb_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, wb_* stable; wb_ready=1 -> IDLE next cycle, next instruction accepted.
- Opcode 0xC -> illegal=1, wb_we=0, br_taken=0, wb_valid still asserted.
- Reset asserted in EXEC and again in WB -> next cycle wb_valid=0, in_ready=1, carry_flag=0, no packet is ever emitted for that instruction.
